// File: rtl/fetch_unit.sv
// Instruction-fetch front end: reads the PC, issues word reads to I-memory,
// hands instructions to decode over valid/ready and advances or redirects the PC.
module fetch_unit #(
  parameter int unsigned          WIDTH    = 32,
  parameter logic [WIDTH-1:0]     RESET_PC = 32'h80000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] pc_in,
  output logic             pc_load,
  output logic [WIDTH-1:0] pc_next,
  output logic             imem_read,
  output logic [WIDTH-1:0] imem_address,
  input  logic [WIDTH-1:0] imem_rdata,
  input  logic             imem_resp,
  input  logic             redirect,
  input  logic [WIDTH-1:0] redirect_pc,
  output logic             inst_valid,
  input  logic             inst_ready,
  output logic [WIDTH-1:0] inst,
  output logic [WIDTH-1:0] inst_pc
);

  typedef enum logic [1:0] {IDLE, REQ, HOLD, DROP} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] addr_q;
  logic [WIDTH-1:0] pc_aligned;
  logic [WIDTH-1:0] redirect_aligned;
  logic             load_addr;
  logic             capture;
  logic             clear_valid;
  logic             pc_load_raw;
  logic             unused_low_bits;

  assign pc_aligned       = {pc_in[WIDTH-1:2], 2'b00};
  assign redirect_aligned = {redirect_pc[WIDTH-1:2], 2'b00};
  assign unused_low_bits  = ^{pc_in[1:0], redirect_pc[1:0]};

  assign imem_read    = (state_q == REQ) || (state_q == DROP);
  assign imem_address = addr_q;
  // The PC register must never see a load while this block is held in reset.
  assign pc_load      = pc_load_raw & rst_n;

  always_comb begin
    state_d     = state_q;
    load_addr   = 1'b0;
    capture     = 1'b0;
    clear_valid = 1'b0;
    pc_load_raw = 1'b0;
    pc_next     = redirect_aligned;
    if (redirect) begin
      pc_load_raw = 1'b1;
      clear_valid = 1'b1;
      unique case (state_q)
        IDLE, HOLD: state_d = IDLE;
        REQ, DROP:  state_d = imem_resp ? IDLE : DROP;
        default:    state_d = IDLE;
      endcase
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d   = REQ;
          load_addr = 1'b1;
        end
        REQ: begin
          if (imem_resp) begin
            capture     = 1'b1;
            pc_load_raw = 1'b1;
            pc_next     = addr_q + WIDTH'(4);
            state_d     = HOLD;
          end
        end
        HOLD: begin
          if (inst_ready) begin
            clear_valid = 1'b1;
            load_addr   = 1'b1;
            state_d     = REQ;
          end
        end
        DROP: begin
          if (imem_resp) begin
            load_addr = 1'b1;
            state_d   = REQ;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      inst       <= '0;
      inst_pc    <= RESET_PC;
      inst_valid <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load_addr) addr_q <= pc_aligned;
      if (capture) begin
        inst       <= imem_rdata;
        inst_pc    <= addr_q;
        inst_valid <= 1'b1;
      end else if (clear_valid) begin
        inst_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios followed by random redirect/ready/latency
// traffic, checked against a transaction-level model of the expected PC stream.
module tb_fetch_unit;

  localparam logic [31:0] RPC = 32'h80000000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc_in;
  logic        pc_load;
  logic [31:0] pc_next;
  logic        imem_read;
  logic [31:0] imem_address;
  logic [31:0] imem_rdata;
  logic        imem_resp;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;

  fetch_unit #(.WIDTH(32), .RESET_PC(RPC)) dut (
    .clk(clk), .rst_n(rst_n), .pc_in(pc_in), .pc_load(pc_load), .pc_next(pc_next),
    .imem_read(imem_read), .imem_address(imem_address), .imem_rdata(imem_rdata),
    .imem_resp(imem_resp), .redirect(redirect), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc)
  );

  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned delivered = 0;

  // Environment: PC register, memory responder, and the expected-stream model.
  logic [31:0] pc_reg;
  logic [31:0] exp_pc;
  logic        wrong_path;
  logic        busy;
  int          cnt;
  int          lat;

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return a ^ 32'h80000013;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle, entered and left at the negative edge.
  task automatic tick(input logic rd, input logic [31:0] rpc, input logic rdy);
    logic        pl_s;
    logic [31:0] pn_s;
    redirect    = rd;
    redirect_pc = rpc;
    inst_ready  = rdy;
    pc_in       = pc_reg;
    imem_resp   = 1'b0;
    imem_rdata  = $urandom;
    if (imem_read && !busy) begin
      busy = 1'b1;
      cnt  = (lat < 0) ? int'($urandom_range(0, 3)) : lat;
    end
    if (busy) begin
      if (cnt == 0) begin
        imem_resp  = 1'b1;
        imem_rdata = memfn(imem_address);
        busy       = 1'b0;
      end else begin
        cnt--;
      end
    end
    #1;
    pl_s = pc_load;
    pn_s = pc_next;
    if (imem_read && !wrong_path) chk("read_addr", imem_address, exp_pc);
    if (imem_read) chk("valid_during_read", inst_valid, 0);
    if (rd) begin
      chk("redir_load", pc_load, 1);
      chk("redir_next", pc_next, {rpc[31:2], 2'b00});
      if (imem_read) wrong_path = !imem_resp;
      exp_pc = {rpc[31:2], 2'b00};
    end else if (imem_read && imem_resp) begin
      if (wrong_path) begin
        chk("drop_noload", pc_load, 0);
        wrong_path = 1'b0;
      end else begin
        chk("resp_load", pc_load, 1);
        chk("resp_next", pc_next, exp_pc + 32'd4);
      end
    end else begin
      chk("no_load", pc_load, 0);
    end
    if (!rd && inst_valid && rdy) begin
      chk("inst_pc", inst_pc, exp_pc);
      chk("inst", inst, memfn(exp_pc));
      exp_pc = exp_pc + 32'd4;
      delivered++;
    end
    @(posedge clk);
    if (pl_s) pc_reg = pn_s;
    @(negedge clk);
  endtask

  task automatic model_reset();
    pc_reg     = RPC;
    exp_pc     = RPC;
    wrong_path = 1'b0;
    busy       = 1'b0;
    cnt        = 0;
    imem_resp  = 1'b0;
  endtask

  initial begin
    rst_n       = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 32'h12345678;
    inst_ready  = 1'b0;
    imem_rdata  = '0;
    pc_in       = RPC;
    lat         = 2;
    model_reset();
    #12;
    chk("rst_valid", inst_valid, 0);
    chk("rst_inst", inst, 0);
    chk("rst_inst_pc", inst_pc, RPC);
    chk("rst_read", imem_read, 0);
    chk("rst_load", pc_load, 0);
    redirect = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // First fetch after reset, 3-cycle latency, decode stalls.
    tick(0, '0, 0);
    chk("first_read", imem_read, 1);
    chk("first_addr", imem_address, RPC);
    repeat (8) tick(0, '0, 0);
    chk("hold_valid", inst_valid, 1);
    chk("hold_inst", inst, 32'h00000013);
    chk("hold_inst_pc", inst_pc, RPC);
    chk("hold_read", imem_read, 0);
    chk("hold_pcreg", pc_reg, 32'h80000004);
    tick(0, '0, 1);
    chk("second_addr", imem_address, 32'h80000004);

    // Redirect while a read is pending: read persists, data discarded.
    tick(1, 32'h80000103, 0);
    chk("drop_read", imem_read, 1);
    chk("drop_addr_held", imem_address, 32'h80000004);
    chk("drop_valid", inst_valid, 0);
    repeat (2) tick(0, '0, 1);
    chk("target_addr", imem_address, 32'h80000100);
    chk("target_pcreg", pc_reg, 32'h80000100);

    // Redirect in the same cycle as the response.
    lat = 0;
    tick(1, 32'h80000203, 0);
    chk("same_cycle_valid", inst_valid, 0);
    tick(0, '0, 0);
    tick(0, '0, 0);
    chk("after_redir_inst_pc", inst_pc, 32'h80000200);

    // Redirect with inst_ready in HOLD drops the instruction; then address wrap.
    tick(1, 32'hFFFFFFFF, 1);
    repeat (3) tick(0, '0, 1);
    chk("wrap_pcreg", pc_reg, 32'h00000000);
    chk("wrap_addr", imem_address, 32'h00000000);

    // Async reset in the middle of a read, then a stray response in IDLE.
    lat = 3;
    tick(0, '0, 0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_read", imem_read, 0);
    chk("async_valid", inst_valid, 0);
    chk("async_load", pc_load, 0);
    model_reset();
    @(negedge clk);
    rst_n      = 1'b1;
    pc_in      = RPC;
    imem_resp  = 1'b1;
    imem_rdata = 32'hDEADBEEF;
    #1;
    chk("stray_resp_load", pc_load, 0);
    @(posedge clk);
    @(negedge clk);
    imem_resp = 1'b0;
    #1;
    chk("stray_resp_valid", inst_valid, 0);
    chk("stray_resp_addr", imem_address, RPC);
    @(negedge clk);
    busy = 1'b0;

    // Random traffic.
    lat = -1;
    for (int i = 0; i < 3000; i++) begin
      logic        rd;
      logic [31:0] rpc;
      rd  = ($urandom_range(0, 9) == 0);
      rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFFFFF0 | 32'($urandom_range(0, 15))) : $urandom;
      tick(rd, rpc, 1'($urandom_range(0, 1)));
    end
    chk("progress", 32'(delivered > 100), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
